// File: rtl/cmp_strobe_sampler_pkg.sv
// Shared definitions for the comparator strobe/sample front end.
// Holds the FSM state type and the width helpers used by the sampler.
package cmp_strobe_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PULSE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } smp_state_t;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to hold the largest reload value (longest phase minus one).
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cmp_strobe_sampler_cdc_sync2.sv
// Two-flop synchroniser for an asynchronous comparator output.
// Both stages clear on the synchronous reset.
module cdc_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cmp_strobe_sampler.sv
// Strobe/sample front end: settles the delay line, fires comparator strobes,
// counts synchronised master/slave results and returns a majority vote.
//
// state  | meaning
// IDLE   | waiting for stb_req_i
// SETTLE | delay line settling before the first strobe
// PULSE  | strobe_o high
// WAIT   | comparator delay plus synchroniser latency
// SAMPLE | accumulate one synchronised sample pair
// DONE   | one-cycle result-valid pulse
module cmp_strobe_sampler
    import cmp_strobe_sampler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int NUM_SAMPLES   = 15,
    parameter int STB_WIDTH     = 2,
    parameter int CMP_LAT       = 3,
    localparam int CW = cnt_width(NUM_SAMPLES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stb_req_i,
    input  logic          abort_i,
    input  logic          m_cmp_i,
    input  logic          s_cmp_i,
    output logic          strobe_o,
    output logic          stb_valid_o,
    output logic          m_cmp_out_o,
    output logic          s_cmp_out_o,
    output logic [CW-1:0] m_cnt_o,
    output logic [CW-1:0] s_cnt_o,
    output logic          busy_o
);

    localparam int TW = tmr_width(SETTLE_CYCLES, STB_WIDTH, CMP_LAT);
    localparam int IW = (NUM_SAMPLES < 2) ? 1 : $clog2(NUM_SAMPLES);

    localparam logic [TW-1:0] LD_SETTLE = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] LD_PULSE  = TW'(STB_WIDTH - 1);
    localparam logic [TW-1:0] LD_WAIT   = TW'(CMP_LAT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_SAMPLES - 1);
    localparam logic [CW:0]   NS_LIM    = (CW + 1)'(NUM_SAMPLES);

    if ((NUM_SAMPLES < 1) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
        $error("cmp_strobe_sampler: NUM_SAMPLES must be odd and >= 1");
    end
    if (SETTLE_CYCLES < 0) begin : g_bad_settle
        $error("cmp_strobe_sampler: SETTLE_CYCLES must be >= 0");
    end
    if (STB_WIDTH < 1) begin : g_bad_stb_width
        $error("cmp_strobe_sampler: STB_WIDTH must be >= 1");
    end
    if (CMP_LAT < 2) begin : g_bad_cmp_lat
        $error("cmp_strobe_sampler: CMP_LAT must be >= 2");
    end

    smp_state_t    r_state;
    smp_state_t    w_state_nxt;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_m_acc;
    logic [CW-1:0] r_s_acc;
    logic [CW-1:0] w_m_tot;
    logic [CW-1:0] w_s_tot;
    logic          w_m_sync;
    logic          w_s_sync;
    logic          r_strobe;
    logic          r_valid;
    logic          r_m_out;
    logic          r_s_out;
    logic [CW-1:0] r_m_cnt;
    logic [CW-1:0] r_s_cnt;

    cdc_sync2 u_sync_m (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (m_cmp_i),
        .o_q   (w_m_sync)
    );

    cdc_sync2 u_sync_s (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (s_cmp_i),
        .o_q   (w_s_sync)
    );

    // Totals including the sample taken this cycle; used when entering DONE.
    assign w_m_tot = r_m_acc + CW'(w_m_sync);
    assign w_s_tot = r_s_acc + CW'(w_s_sync);

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = (r_tmr != '0) ? (r_tmr - TW'(1)) : '0;
        unique case (r_state)
            ST_IDLE: begin
                if (stb_req_i) begin
                    if (SETTLE_CYCLES == 0) begin
                        w_state_nxt = ST_PULSE;
                        w_tmr_nxt   = LD_PULSE;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_nxt   = LD_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_tmr == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_tmr_nxt   = LD_PULSE;
                end
            end
            ST_PULSE: begin
                if (r_tmr == '0) begin
                    w_state_nxt = ST_WAIT;
                    w_tmr_nxt   = LD_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_tmr == '0) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_PULSE;
                    w_tmr_nxt   = LD_PULSE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_tmr    <= '0;
            r_idx    <= '0;
            r_m_acc  <= '0;
            r_s_acc  <= '0;
            r_strobe <= 1'b0;
            r_valid  <= 1'b0;
            r_m_out  <= 1'b0;
            r_s_out  <= 1'b0;
            r_m_cnt  <= '0;
            r_s_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tmr    <= w_tmr_nxt;
            r_strobe <= (w_state_nxt == ST_PULSE);
            r_valid  <= (w_state_nxt == ST_DONE);

            if (r_state == ST_IDLE) begin
                r_idx   <= '0;
                r_m_acc <= '0;
                r_s_acc <= '0;
            end else if (r_state == ST_SAMPLE) begin
                r_m_acc <= w_m_tot;
                r_s_acc <= w_s_tot;
                if (r_idx != IDX_LAST) begin
                    r_idx <= r_idx + IW'(1);
                end
            end

            if (w_state_nxt == ST_DONE) begin
                r_m_cnt <= w_m_tot;
                r_s_cnt <= w_s_tot;
                r_m_out <= ({w_m_tot, 1'b0} > NS_LIM);
                r_s_out <= ({w_s_tot, 1'b0} > NS_LIM);
            end
        end
    end

    assign strobe_o    = r_strobe;
    assign stb_valid_o = r_valid;
    assign m_cmp_out_o = r_m_out;
    assign s_cmp_out_o = r_s_out;
    assign m_cnt_o     = r_m_cnt;
    assign s_cnt_o     = r_s_cnt;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
